// File: rtl/alu_mod_unit.sv
// Iterative unsigned modulo (A mod B) by repeated subtraction with a start/done handshake.
// Optional macro ALU_MOD_QUOTIENT_EN adds a registered quotient output.
module alu_mod_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
`ifdef ALU_MOD_QUOTIENT_EN
    output logic [WIDTH-1:0] quotient,
`endif
    output logic             div_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SUB  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] bq_q, bq_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             div_zero_q, div_zero_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
`ifdef ALU_MOD_QUOTIENT_EN
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
`endif

    // Same add/subtract convention as the ALU slices; carry-out set means R >= Bq.
    logic [WIDTH:0] diff;
    logic           carry;

    assign diff  = {1'b0, r_q} + {1'b0, ~bq_q} + {{WIDTH{1'b0}}, 1'b1};
    assign carry = diff[WIDTH];

    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        bq_d       = bq_q;
        result_d   = result_q;
        div_zero_d = div_zero_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
`ifdef ALU_MOD_QUOTIENT_EN
        cnt_d      = cnt_q;
        quotient_d = quotient_q;
`endif
        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    r_d    = a;
                    bq_d   = b;
                    busy_d = 1'b1;
`ifdef ALU_MOD_QUOTIENT_EN
                    cnt_d  = '0;
`endif
                    if (b == '0) begin
                        result_d   = a;
                        div_zero_d = 1'b1;
                        done_d     = 1'b1;
                        state_d    = DONE;
`ifdef ALU_MOD_QUOTIENT_EN
                        quotient_d = '1;
`endif
                    end else begin
                        state_d = SUB;
                    end
                end
            end
            SUB: begin
                if (carry) begin
                    r_d = diff[WIDTH-1:0];
`ifdef ALU_MOD_QUOTIENT_EN
                    cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
`endif
                end else begin
                    result_d   = r_q;
                    div_zero_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = DONE;
`ifdef ALU_MOD_QUOTIENT_EN
                    quotient_d = cnt_q;
`endif
                end
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            r_q        <= '0;
            bq_q       <= '0;
            result_q   <= '0;
            div_zero_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef ALU_MOD_QUOTIENT_EN
            cnt_q      <= '0;
            quotient_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            r_q        <= r_d;
            bq_q       <= bq_d;
            result_q   <= result_d;
            div_zero_q <= div_zero_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
`ifdef ALU_MOD_QUOTIENT_EN
            cnt_q      <= cnt_d;
            quotient_q <= quotient_d;
`endif
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign div_zero = div_zero_q;
`ifdef ALU_MOD_QUOTIENT_EN
    assign quotient = quotient_q;
`endif

endmodule

// File: tb/tb_alu_mod_unit.sv
// Self-checking bench for alu_mod_unit: directed scenarios plus randomized operands
// checked against a plain-arithmetic reference model.
module tb_alu_mod_unit;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        div_zero;
`ifdef ALU_MOD_QUOTIENT_EN
    logic [31:0] quotient;
`endif

    int passed = 0;
    int total  = 0;

    alu_mod_unit #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .busy     (busy),
        .done     (done),
        .result   (result),
`ifdef ALU_MOD_QUOTIENT_EN
        .quotient (quotient),
`endif
        .div_zero (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: the arithmetic meaning of the operation, not the datapath.
    function automatic logic [31:0] ref_mod(input logic [31:0] x, input logic [31:0] y);
        return (y == 0) ? x : x % y;
    endfunction

    function automatic logic [31:0] ref_quot(input logic [31:0] x, input logic [31:0] y);
        return (y == 0) ? 32'hFFFF_FFFF : x / y;
    endfunction

    function automatic int ref_lat(input logic [31:0] x, input logic [31:0] y);
        return (y == 0) ? 1 : int'(x / y) + 2;
    endfunction

    task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        else passed++;
    endtask

    // Runs one operation; lat is the cycle (start edge = 0) in which done was seen, -1 on timeout.
    task automatic run_op(input logic [31:0] op_a, input logic [31:0] op_b, input int limit,
                          output int lat, output bit busy_ok, output logic [31:0] res,
                          output logic dz, output logic [31:0] quo, output bit pulse_ok);
        @(negedge clk);
        a = op_a;
        b = op_b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < limit) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        if (done !== 1'b1) lat = -1;
        else if (busy !== 1'b1) busy_ok = 1'b0;
        res = result;
        dz  = div_zero;
`ifdef ALU_MOD_QUOTIENT_EN
        quo = quotient;
`else
        quo = 32'h0;
`endif
        @(posedge clk);
        #1;
        pulse_ok = (done === 1'b0) && (busy === 1'b0) && (result === res);
    endtask

    task automatic test_reset();
        start = 1'b0;
        a = '0;
        b = '0;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({busy, done, div_zero} !== 3'b000 || result !== 32'h0) begin
            $display("FAIL reset_state: busy=%b done=%b dz=%b result=0x%08h, expected all zero",
                     busy, done, div_zero, result);
        end else passed++;
    endtask

    task automatic test_directed(input logic [31:0] op_a, input logic [31:0] op_b, input string tag);
        int lat;
        bit busy_ok, pulse_ok;
        logic [31:0] res, quo;
        logic dz;
        run_op(op_a, op_b, ref_lat(op_a, op_b) + 20, lat, busy_ok, res, dz, quo, pulse_ok);
        total++;
        if (lat !== ref_lat(op_a, op_b))
            $display("FAIL %s_latency: got %0d expected %0d", tag, lat, ref_lat(op_a, op_b));
        else passed++;
        check32({tag, "_result"}, res, ref_mod(op_a, op_b));
        total++;
        if (dz !== (op_b == 0)) $display("FAIL %s_div_zero: got %b expected %b", tag, dz, op_b == 0);
        else passed++;
        total++;
        if (!busy_ok || !pulse_ok)
            $display("FAIL %s_handshake: busy_ok=%0d pulse_ok=%0d expected 1/1", tag, busy_ok, pulse_ok);
        else passed++;
`ifdef ALU_MOD_QUOTIENT_EN
        check32({tag, "_quotient"}, quo, ref_quot(op_a, op_b));
`endif
    endtask

    task automatic test_ignore_while_busy();
        int lat;
        bit busy_ok;
        @(negedge clk);
        a = 100;
        b = 7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 1;
        busy_ok = 1'b1;
        while (done !== 1'b1 && lat < 40) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (lat == 3) begin
                start = 1'b1;
                a = 1;
                b = 1;
            end else start = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        if (done !== 1'b1) lat = -1;
        total++;
        if (lat != 16 || !busy_ok)
            $display("FAIL ignore_busy_latency: got %0d busy_ok=%0d expected 16 busy_ok=1", lat, busy_ok);
        else passed++;
        check32("ignore_busy_result", result, 32'd2);
        // Hold start through the done cycle: it must not be accepted.
        start = 1'b1;
        a = 50;
        b = 7;
        @(posedge clk);
        #1;
        start = 1'b0;
        total++;
        if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL start_on_done: busy=%b done=%b expected 0/0", busy, done);
        else passed++;
        repeat (3) @(posedge clk);
        #1;
        check32("start_on_done_result_held", result, 32'd2);
    endtask

    task automatic test_reset_abort();
        bit done_seen;
        @(negedge clk);
        a = 1000;
        b = 1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (49) @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        total++;
        if ({busy, done, div_zero} !== 3'b000 || result !== 32'h0)
            $display("FAIL reset_abort: busy=%b done=%b dz=%b result=0x%08h expected zero",
                     busy, done, div_zero, result);
        else passed++;
        done_seen = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen = 1'b1;
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
        end
        total++;
        if (done_seen) $display("FAIL reset_no_done: done/busy seen=1 expected 0");
        else passed++;
        test_directed(32'd10, 32'd4, "after_reset");
    endtask

    task automatic test_random(input int n);
        logic [31:0] rb, rr, ra;
        logic [63:0] prod;
        int k;
        for (int i = 0; i < n; i++) begin
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom_range(1, 20);
                default: rb = $urandom | 32'h1;
            endcase
            k  = $urandom_range(0, 200);
            rr = (rb == 0) ? $urandom : $urandom % rb;
            prod = 64'(rb) * 64'(k) + 64'(rr);
            ra = (prod > 64'hFFFF_FFFF) ? rr : prod[31:0];
            test_directed(ra, rb, "random");
        end
    endtask

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_directed(32'd7, 32'd3, "mod_7_3");
        test_directed(32'd5, 32'd9, "a_lt_b");
        test_directed(32'd12, 32'd12, "a_eq_b");
        test_directed(32'h1234, 32'd0, "div_zero");
        test_directed(32'd10, 32'd4, "after_div_zero");
        test_ignore_while_busy();
        test_reset_abort();
        test_random(20);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
